router_src_arbiter: RTL and testbench

- Input-side arbiter that lets three packet sources share the 1x3 router's single ingress port: pkt_valid, the 8-bit data byte, and busy backpressure.
- Grants one source at a time, round-robin, holding the grant for a whole packet (header, payload, parity).
- Sequences pkt_valid as the router expects, stalls on busy, and inserts an inter-packet gap.
- Optionally discards packets addressed to the invalid destination 2'b11.

---
 rtl/router_src_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_router_src_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_src_arbiter.sv
// Round-robin ingress arbiter: three packet sources share one router port, each grant held
// for a whole packet (header, payload, parity), with an inter-packet gap and optional invalid-dest drop.
module router_src_arbiter #(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter bit          DROP_INVALID = 1'b1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] src_rdy,
  input  logic [7:0] src_data_0,
  input  logic [7:0] src_data_1,
  input  logic [7:0] src_data_2,
  output logic [2:0] src_ack,
  output logic [2:0] src_gnt,
  input  logic       busy,
  output logic       rtr_pkt_valid,
  output logic [7:0] rtr_data,
  output logic       pkt_done,
  output logic       pkt_drop,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] gnt_q, gnt_d;
  logic       drop_q, drop_d;
  logic       done_q, done_d;
  logic       dropped_q, dropped_d;

  logic [7:0] cur_byte;
  logic [1:0] gnt_idx;
  logic       hdr_invalid;
  logic       accept;

  // First requester at or after ptr, wrapping modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    pick = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd2: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
    return pick;
  endfunction

  always_comb begin
    cur_byte = src_data_0;
    gnt_idx  = 2'd0;
    case (gnt_q)
      3'b010: begin
        cur_byte = src_data_1;
        gnt_idx  = 2'd1;
      end
      3'b100: begin
        cur_byte = src_data_2;
        gnt_idx  = 2'd2;
      end
      default: begin
        cur_byte = src_data_0;
        gnt_idx  = 2'd0;
      end
    endcase
  end

  assign hdr_invalid = DROP_INVALID && (cur_byte[1:0] == 2'b11);

  // Handshake: a byte moves when src_ack[k] is high at a rising edge; src_ack is high only
  // when !busy, or unconditionally while a packet is being dropped. The source advances next cycle.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    gnt_d         = gnt_q;
    drop_d        = drop_q;
    done_d        = 1'b0;
    dropped_d     = 1'b0;
    accept        = 1'b0;
    src_ack       = 3'b000;
    rtr_pkt_valid = 1'b0;
    rtr_data      = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (|src_rdy) begin
          gnt_d   = rr_pick(src_rdy, rr_ptr_q);
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        rtr_data      = cur_byte;
        rtr_pkt_valid = !hdr_invalid;
        accept        = !busy || hdr_invalid;
        if (accept) begin
          src_ack = gnt_q;
          cnt_d   = cur_byte[7:2];
          drop_d  = hdr_invalid;
          state_d = (cur_byte[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
        end
      end
      S_PAYLOAD: begin
        if (drop_q) begin
          accept = 1'b1;
        end else begin
          rtr_pkt_valid = 1'b1;
          rtr_data      = cur_byte;
          accept        = !busy;
        end
        if (accept) begin
          src_ack = gnt_q;
          cnt_d   = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        rtr_data = drop_q ? 8'h00 : cur_byte;
        accept   = drop_q || !busy;
        if (accept) begin
          src_ack   = gnt_q;
          done_d    = !drop_q;
          dropped_d = drop_q;
          rr_ptr_d  = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
          gnt_d     = 3'b000;
          drop_d    = 1'b0;
          gap_d     = 4'(GAP_CYCLES);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= 2'd0;
      cnt_q     <= 6'd0;
      gap_q     <= 4'd0;
      gnt_q     <= 3'b000;
      drop_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      gnt_q     <= gnt_d;
      drop_q    <= drop_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign src_gnt   = gnt_q;
  assign pkt_done  = done_q;
  assign pkt_drop  = dropped_q;
  assign dbg_state = state_q;

  a_gnt_onehot: assert property (@(posedge clock) disable iff (resetn) $onehot0(gnt_q));
  a_ack_in_gnt: assert property (@(posedge clock) disable iff (resetn) (src_ack & ~gnt_q) == 3'b000);

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: queue-backed source models, a negedge monitor scoring router
// bytes and grants against expected queues, and one task per scenario.
module tb_router_src_arbiter;

  localparam int GAP = 2;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] src_rdy = 3'b000;
  logic [7:0] src_data_0 = 8'h00;
  logic [7:0] src_data_1 = 8'h00;
  logic [7:0] src_data_2 = 8'h00;
  logic       busy = 1'b0;
  logic [2:0] src_ack;
  logic [2:0] src_gnt;
  logic       rtr_pkt_valid;
  logic [7:0] rtr_data;
  logic       pkt_done;
  logic       pkt_drop;
  logic [2:0] dbg_state;

  router_src_arbiter #(.GAP_CYCLES(GAP), .DROP_INVALID(1'b1)) dut (
    .clock(clock), .resetn(resetn), .src_rdy(src_rdy),
    .src_data_0(src_data_0), .src_data_1(src_data_1), .src_data_2(src_data_2),
    .src_ack(src_ack), .src_gnt(src_gnt), .busy(busy),
    .rtr_pkt_valid(rtr_pkt_valid), .rtr_data(rtr_data),
    .pkt_done(pkt_done), .pkt_drop(pkt_drop), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid, n_ack, n_done, n_drop, n_gap, first_ack, last_ack;

  logic [8:0] exp_q[$];
  logic [2:0] exp_gnt_q[$];
  logic [7:0] q0[$], q1[$], q2[$];
  logic [2:0] ack_lat = 3'b000;
  logic [2:0] prev_gnt = 3'b000;

  task automatic update_src();
    src_rdy    = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    src_data_0 = (q0.size() != 0) ? q0[0] : 8'h00;
    src_data_1 = (q1.size() != 0) ? q1[0] : 8'h00;
    src_data_2 = (q2.size() != 0) ? q2[0] : 8'h00;
  endtask

  task automatic flush_src();
    q0.delete();
    q1.delete();
    q2.delete();
    update_src();
  endtask

  task automatic clear_counts();
    n_valid = 0; n_ack = 0; n_done = 0; n_drop = 0; n_gap = 0;
    first_ack = 0; last_ack = 0;
  endtask

  // driver: queue a whole packet on source k; forwarded packets also feed the scoreboard
  task automatic push_pkt(input int k, input logic [7:0] hdr, input logic [7:0] base,
                          input logic [7:0] par, input bit fwd);
    logic [7:0] pkt[$];
    int len;
    len = int'(hdr[7:2]);
    pkt.push_back(hdr);
    for (int i = 0; i < len; i++) pkt.push_back(base + 8'(i));
    pkt.push_back(par);
    for (int i = 0; i < pkt.size(); i++) begin
      case (k)
        0: q0.push_back(pkt[i]);
        1: q1.push_back(pkt[i]);
        default: q2.push_back(pkt[i]);
      endcase
      if (fwd) exp_q.push_back({(i == pkt.size() - 1), pkt[i]});
    end
    update_src();
  endtask

  // source model: advance acked sources just after the edge that consumed the byte
  initial begin
    logic [7:0] tmp;
    forever begin
      @(posedge clock);
      #1;
      if (ack_lat[0] && q0.size() != 0) tmp = q0.pop_front();
      if (ack_lat[1] && q1.size() != 0) tmp = q1.pop_front();
      if (ack_lat[2] && q2.size() != 0) tmp = q2.pop_front();
      update_src();
    end
  end

  // monitor / scoreboard
  initial begin
    logic [8:0] e;
    logic [2:0] g;
    forever begin
      @(negedge clock);
      cyc++;
      if (resetn) begin
        ack_lat  = 3'b000;
        prev_gnt = 3'b000;
      end else begin
        ack_lat = src_ack;
        if (rtr_pkt_valid && !busy) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL fwd_byte: got %h, required no byte", rtr_data);
          end else begin
            e = exp_q.pop_front();
            if ({1'b0, rtr_data} !== e) begin
              bad++;
              $display("FAIL fwd_byte: got %h, required %h (par=%0b)", rtr_data, e[7:0], e[8]);
            end
          end
        end
        if (dbg_state == ST_PARITY && src_ack != 3'b000 && rtr_data != 8'h00) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL parity_byte: got %h, required no byte", rtr_data);
          end else begin
            e = exp_q.pop_front();
            if ({1'b1, rtr_data} !== e) begin
              bad++;
              $display("FAIL parity_byte: got %h, required %h (par=%0b)", rtr_data, e[7:0], e[8]);
            end
          end
        end
        if (src_gnt != 3'b000 && prev_gnt == 3'b000) begin
          total++;
          if (exp_gnt_q.size() == 0) begin
            bad++;
            $display("FAIL grant: got %b, required no grant", src_gnt);
          end else begin
            g = exp_gnt_q.pop_front();
            if (src_gnt !== g) begin
              bad++;
              $display("FAIL grant: got %b, required %b", src_gnt, g);
            end
          end
        end
        if (src_ack != 3'b000) begin
          total++;
          if (src_ack !== src_gnt) begin
            bad++;
            $display("FAIL ack_vs_gnt: ack=%b, required grant %b", src_ack, src_gnt);
          end
          if (n_ack == 0) first_ack = cyc;
          last_ack = cyc;
          n_ack++;
        end
        if (rtr_pkt_valid) n_valid++;
        if (pkt_done) n_done++;
        if (pkt_drop) n_drop++;
        if (dbg_state == ST_GAP) n_gap++;
        prev_gnt = src_gnt;
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    busy   = 1'b0;
    flush_src();
    exp_q.delete();
    exp_gnt_q.delete();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    clear_counts();
  endtask

  task automatic wait_done(input string name, input int want_done, input int want_drop);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clock);
      #1;
      if (n_done >= want_done && n_drop >= want_drop) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL %s_timeout: done=%0d drop=%0d, required %0d/%0d", name, n_done, n_drop,
               want_done, want_drop);
    end
    repeat (GAP + 3) @(posedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover_bytes: %0d left, required 0", name, exp_q.size());
    end
    total++;
    if (exp_gnt_q.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover_grants: %0d left, required 0", name, exp_gnt_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++;
    if ({src_gnt, src_ack, rtr_pkt_valid, rtr_data, pkt_done, pkt_drop, dbg_state} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b ack=%b v=%b d=%h done=%b drop=%b st=%0d, required all 0",
               src_gnt, src_ack, rtr_pkt_valid, rtr_data, pkt_done, pkt_drop, dbg_state);
    end
    @(posedge clock);
    #1;
    resetn = 1'b0;
    clear_counts();
    @(negedge clock);
    total++;
    if (dbg_state !== ST_IDLE || src_gnt !== 3'b000 || rtr_pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: st=%0d gnt=%b v=%b, required 0/000/0", dbg_state, src_gnt,
               rtr_pkt_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    push_pkt(1, 8'h0D, 8'hA1, 8'h5A, 1'b1);
    exp_gnt_q.push_back(3'b010);
    wait_done("single", 1, 0);
    total++;
    if (n_valid != 4) begin bad++; $display("FAIL single_valid: got %0d, required 4", n_valid); end
    total++;
    if (n_ack != 5) begin bad++; $display("FAIL single_ack: got %0d, required 5", n_ack); end
    total++;
    if (n_done != 1 || n_drop != 0) begin
      bad++;
      $display("FAIL single_pulses: done=%0d drop=%0d, required 1/0", n_done, n_drop);
    end
    total++;
    if (n_gap != GAP) begin bad++; $display("FAIL single_gap: got %0d, required %0d", n_gap, GAP); end
  endtask

  task automatic test_round_robin();
    do_reset();
    push_pkt(0, 8'h04, 8'h10, 8'h1F, 1'b1);
    push_pkt(1, 8'h05, 8'h20, 8'h2F, 1'b1);
    push_pkt(2, 8'h06, 8'h30, 8'h3F, 1'b1);
    push_pkt(0, 8'h04, 8'h40, 8'h4F, 1'b1);
    exp_gnt_q.push_back(3'b001);
    exp_gnt_q.push_back(3'b010);
    exp_gnt_q.push_back(3'b100);
    exp_gnt_q.push_back(3'b001);
    wait_done("rr", 4, 0);
    total++;
    if (n_valid != 8 || n_ack != 12) begin
      bad++;
      $display("FAIL rr_counts: valid=%0d ack=%0d, required 8/12", n_valid, n_ack);
    end
    total++;
    if (n_gap != 4 * GAP) begin bad++; $display("FAIL rr_gap: got %0d, required %0d", n_gap, 4 * GAP); end
  endtask

  task automatic test_busy_stall();
    bit found;
    do_reset();
    push_pkt(0, 8'h08, 8'hB1, 8'hC3, 1'b1);
    exp_gnt_q.push_back(3'b001);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clock);
      #1;
      if (dbg_state == ST_PAYLOAD) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL busy_reach_payload: state=%0d, required %0d", dbg_state, ST_PAYLOAD); end
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (rtr_pkt_valid !== 1'b1 || rtr_data !== 8'hB1 || src_ack !== 3'b000) begin
        bad++;
        $display("FAIL busy_hold%0d: v=%b d=%h ack=%b, required 1/b1/000", i, rtr_pkt_valid,
                 rtr_data, src_ack);
      end
    end
    @(posedge clock);
    #1;
    busy = 1'b0;
    wait_done("busy", 1, 0);
    total++;
    if (n_valid != 6 || n_ack != 4) begin
      bad++;
      $display("FAIL busy_counts: valid=%0d ack=%0d, required 6/4", n_valid, n_ack);
    end
  endtask

  task automatic test_drop();
    do_reset();
    busy = 1'b1;
    push_pkt(2, 8'h0B, 8'hD1, 8'hE4, 1'b0);
    exp_gnt_q.push_back(3'b100);
    wait_done("drop", 0, 1);
    busy = 1'b0;
    total++;
    if (n_valid != 0) begin bad++; $display("FAIL drop_valid: got %0d, required 0", n_valid); end
    total++;
    if (n_ack != 4 || last_ack - first_ack != 3) begin
      bad++;
      $display("FAIL drop_ack: count=%0d span=%0d, required 4/3", n_ack, last_ack - first_ack);
    end
    total++;
    if (n_drop != 1 || n_done != 0) begin
      bad++;
      $display("FAIL drop_pulses: drop=%0d done=%0d, required 1/0", n_drop, n_done);
    end
  endtask

  task automatic test_len0();
    do_reset();
    push_pkt(0, 8'h02, 8'h00, 8'h77, 1'b1);
    exp_gnt_q.push_back(3'b001);
    wait_done("len0", 1, 0);
    total++;
    if (n_valid != 1 || n_ack != 2 || n_done != 1) begin
      bad++;
      $display("FAIL len0_counts: valid=%0d ack=%0d done=%0d, required 1/2/1", n_valid, n_ack, n_done);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    push_pkt(0, 8'h04, 8'h50, 8'h5F, 1'b1);
    exp_gnt_q.push_back(3'b001);
    wait_done("pre_mid", 1, 0);
    push_pkt(1, 8'h15, 8'h60, 8'h6F, 1'b1);
    exp_gnt_q.push_back(3'b010);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clock);
      #1;
      if (dbg_state == ST_PAYLOAD) found = 1'b1;
    end
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    flush_src();
    exp_q.delete();
    exp_gnt_q.delete();
    @(posedge clock);
    #1;
    resetn = 1'b0;
    clear_counts();
    @(negedge clock);
    total++;
    if ({src_gnt, src_ack, rtr_pkt_valid, rtr_data, pkt_done, pkt_drop, dbg_state} !== 20'h0) begin
      bad++;
      $display("FAIL midreset_outputs: gnt=%b ack=%b v=%b d=%h done=%b drop=%b st=%0d, required all 0",
               src_gnt, src_ack, rtr_pkt_valid, rtr_data, pkt_done, pkt_drop, dbg_state);
    end
    push_pkt(0, 8'h04, 8'h70, 8'h7F, 1'b1);
    push_pkt(2, 8'h06, 8'h80, 8'h8F, 1'b1);
    exp_gnt_q.push_back(3'b001);
    exp_gnt_q.push_back(3'b100);
    wait_done("post_mid", 2, 0);
  endtask

  task automatic test_random();
    logic [7:0] hdr;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      hdr = {6'($urandom_range(0, 6)), 2'($urandom_range(0, 2))};
      push_pkt(p, hdr, 8'($urandom_range(1, 200)), 8'($urandom_range(1, 255)), 1'b1);
      exp_gnt_q.push_back(3'b001 << p);
    end
    wait_done("random", 3, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_stall();
    test_drop();
    test_len0();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
